pwm_output_ctrl: RTL and testbench

//  Consumes the five configuration registers written by the SPI register block.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_timebase.sv | 36 +++
 rtl/pwm_output_ctrl.sv | 59 +++++
 tb/tb_pwm_output_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and the PWM compare rule for the pin output controller.
// DUTY_FULL is treated as "always on" so a full-scale duty has no low slot.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int NUM_PINS = 16;

  // 0x00 never asserts; 0xFF always asserts; D asserts for counts 0..D-1.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    if (duty == DUTY_FULL) begin
      return 1'b1;
    end
    return (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler feeding an 8-bit free-running period counter.
// wrap marks the last clk of each 256*PRESCALE-clk period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 wrap
);

  // PRESCALE=1 keeps a 1-bit pre_cnt pinned at 0, so tick is constant high.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (pwm_cnt == {PWM_CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_output_ctrl.sv
// 16-pin output controller: each pin off, static high, or PWM from a shared timebase.
// Duty is double-buffered and only swapped on the period wrap.
module pwm_output_ctrl
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_PINS-1:0]  out,
  output logic                 period_start
);

  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_active;
  logic                 wrap;
  logic                 pwm;
  logic [NUM_PINS-1:0]  en_out;
  logic [NUM_PINS-1:0]  en_pwm;
  logic [NUM_PINS-1:0]  pin_next;

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_cnt(pwm_cnt),
    .wrap   (wrap)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pwm    = pwm_level(pwm_cnt, duty_active);

  // en_pwm only matters where en_out is set; disabled pins are forced low.
  always_comb begin
    pin_next = en_out & (~en_pwm | {NUM_PINS{pwm}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active  <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      if (wrap) begin
        duty_active <= pwm_duty_cycle;
      end
      out          <= pin_next;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_output_ctrl.sv
// Self-checking bench for pwm_output_ctrl with PRESCALE=2 (512-clk period).
// Reference model derives counter and duty state from elapsed clocks since reset.
module tb_pwm_output_ctrl;

  localparam int P   = 2;
  localparam int PER = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [15:0] out;
  logic        period_start;

  int n_checks = 0;
  int n_pass = 0;

  // model state: clocks since reset release, captured duty, expected outputs
  int          t = 0;
  logic [7:0]  duty_m = '0;
  logic [15:0] exp_out = '0;
  logic        exp_ps = 1'b0;

  pwm_output_ctrl #(.PRESCALE(P)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .out            (out),
    .period_start   (period_start)
  );

  always #5 clk = ~clk;

  // Advance model and DUT by one clk; inputs must be stable across this call.
  task automatic step();
    int   cnt;
    logic pwm;
    cnt = (t / P) % 256;
    pwm = (duty_m == 8'hFF) || (cnt < int'(duty_m));
    exp_out = en_out & (~en_pwm | {16{pwm}});
    if ((t + 1) % PER == 0) duty_m = duty;
    t++;
    exp_ps = (t % PER == 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    t = 0;
    duty_m = '0;
    exp_out = '0;
    exp_ps = 1'b0;
  endtask

  task automatic wait_ps(output bit ok, output int n);
    n = 0;
    ok = 1'b0;
    while (n < PER + 64 && !ok) begin
      step();
      n++;
      if (period_start) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out !== 16'h0000) $display("FAIL reset_out act=%h exp=0000", out);
    else n_pass++;
    n_checks++;
    if (period_start !== 1'b0) $display("FAIL reset_ps act=%b exp=0", period_start);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    int first_ps = -1;
    int n_ps = 0;
    duty = 8'h80;
    for (int i = 1; i <= 2 * PER; i++) begin
      step();
      n_checks++;
      if (out !== exp_out || period_start !== exp_ps)
        $display("FAIL idle_cycle i=%0d act=%h/%b exp=%h/%b", i, out, period_start, exp_out, exp_ps);
      else n_pass++;
      if (period_start) begin
        n_ps++;
        if (first_ps < 0) first_ps = i;
      end
    end
    n_checks++;
    if (first_ps !== PER || n_ps !== 2)
      $display("FAIL idle_ps_spacing act=first %0d count %0d exp=first %0d count 2", first_ps, n_ps, PER);
    else n_pass++;
  endtask

  task automatic test_static();
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    step();
    n_checks++;
    if (out !== 16'hFFFF) $display("FAIL static_latency act=%h exp=ffff", out);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (out !== exp_out) $display("FAIL static_hold act=%h exp=%h", out, exp_out);
      else n_pass++;
    end
  endtask

  task automatic test_pwm_pin0();
    bit ok;
    int n;
    int high = 0;
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty = 8'h80;
    wait_ps(ok, n);
    n_checks++;
    if (!ok) $display("FAIL pin0_wait act=no period_start in %0d clk exp=period_start", n);
    else n_pass++;
    for (int i = 0; i < PER; i++) begin
      step();
      n_checks++;
      if (out !== exp_out || out[15:1] !== 15'h0)
        $display("FAIL pin0_cycle act=%h exp=%h", out, exp_out);
      else n_pass++;
      if (out[0]) high++;
    end
    n_checks++;
    if (high !== 256) $display("FAIL pin0_high act=%0d exp=256", high);
    else n_pass++;
  endtask

  task automatic test_duty_extremes();
    bit ok;
    int n;
    int high0 = 0;
    int high1 = 0;
    duty = 8'h00;
    wait_ps(ok, n);
    n_checks++;
    if (!ok) $display("FAIL ext_wait act=no period_start exp=period_start");
    else n_pass++;
    duty = 8'hFF;
    for (int i = 0; i < PER; i++) begin
      step();
      n_checks++;
      if (out !== exp_out) $display("FAIL ext_zero_cycle act=%h exp=%h", out, exp_out);
      else n_pass++;
      if (out[0]) high0++;
    end
    n_checks++;
    if (period_start !== 1'b1) $display("FAIL ext_align act=%b exp=1", period_start);
    else n_pass++;
    for (int i = 0; i < PER; i++) begin
      step();
      n_checks++;
      if (out !== exp_out) $display("FAIL ext_full_cycle act=%h exp=%h", out, exp_out);
      else n_pass++;
      if (out[0]) high1++;
    end
    n_checks++;
    if (high0 !== 0) $display("FAIL ext_zero_high act=%0d exp=0", high0);
    else n_pass++;
    n_checks++;
    if (high1 !== PER) $display("FAIL ext_full_high act=%0d exp=%0d", high1, PER);
    else n_pass++;
  endtask

  task automatic test_duty_midwrite();
    bit ok;
    int n;
    int high_a = 0;
    int high_b = 0;
    duty = 8'hC0;
    wait_ps(ok, n);
    n_checks++;
    if (!ok) $display("FAIL mid_wait act=no period_start exp=period_start");
    else n_pass++;
    for (int i = 0; i < PER; i++) begin
      if (i == 100) duty = 8'h40;
      step();
      n_checks++;
      if (out !== exp_out) $display("FAIL mid_cycle_a act=%h exp=%h", out, exp_out);
      else n_pass++;
      if (out[0]) high_a++;
    end
    for (int i = 0; i < PER; i++) begin
      step();
      n_checks++;
      if (out !== exp_out) $display("FAIL mid_cycle_b act=%h exp=%h", out, exp_out);
      else n_pass++;
      if (out[0]) high_b++;
    end
    n_checks++;
    if (high_a !== 384) $display("FAIL mid_keep_high act=%0d exp=384", high_a);
    else n_pass++;
    n_checks++;
    if (high_b !== 128) $display("FAIL mid_next_high act=%0d exp=128", high_b);
    else n_pass++;
  endtask

  task automatic test_wrap_write();
    bit ok;
    int n;
    int high = 0;
    wait_ps(ok, n);
    n_checks++;
    if (!ok) $display("FAIL wrapw_wait act=no period_start exp=period_start");
    else n_pass++;
    repeat (PER - 2) step();
    duty = 8'h90;
    step();
    duty = 8'h10;
    step();
    n_checks++;
    if (period_start !== 1'b1) $display("FAIL wrapw_align act=%b exp=1", period_start);
    else n_pass++;
    for (int i = 0; i < PER; i++) begin
      step();
      if (out[0]) high++;
    end
    n_checks++;
    if (high !== 32) $display("FAIL wrapw_high act=%0d exp=32", high);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * PER; i++) begin
      case ($urandom_range(0, 31))
        0: en_out = 16'($urandom);
        1: en_pwm = 16'($urandom);
        2: duty   = 8'($urandom);
        default: ;
      endcase
      step();
      n_checks++;
      if (out !== exp_out || period_start !== exp_ps)
        $display("FAIL random_cycle t=%0d act=%h/%b exp=%h/%b", t, out, period_start, exp_out, exp_ps);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    repeat (100) step();
    n_checks++;
    if (out !== 16'hFFFF) $display("FAIL rstmid_pre act=%h exp=ffff", out);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== 16'h0000 || period_start !== 1'b0)
      $display("FAIL rstmid_async act=%h/%b exp=0000/0", out, period_start);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ok = 1'b0;
    n = 0;
    while (n < PER + 64 && !ok) begin
      step();
      n++;
      n_checks++;
      if (out !== exp_out || period_start !== exp_ps)
        $display("FAIL rstmid_cycle n=%0d act=%h/%b exp=%h/%b", n, out, period_start, exp_out, exp_ps);
      else n_pass++;
      if (period_start) ok = 1'b1;
    end
    n_checks++;
    if (!ok || n !== PER) $display("FAIL rstmid_first_ps act=%0d clk exp=%0d clk", n, PER);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_static();
    test_pwm_pin0();
    test_duty_extremes();
    test_duty_midwrite();
    test_wrap_write();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
